mm_round_ctrl: RTL and testbench
================================

// Module: mm_round_ctrl
// PURPOSE
//  Sequencer for the prefix-doubling (Manber-Myers) suffix-array sorter. Issues the
//  initial rank load, then one sort round per doubling offset (1,2,4,...) until ranks
//  are unique or offset reaches N. Then streams suffix indices 0..N-1 to the BWT
//  output stage over a valid/ready handshake. Sits between the top FSM and the sorter.
// PARAMETERS
//  N        8     string length incl. '$'; power of two, >=2
//  W        4     round counter width; must hold clog2(N)+1
//  TIMEOUT  1024  max cycles in SORT_WAIT before error abort
// PORTS
//  clk          in   1          rising-edge clock
//  rst          in   1          async reset, active-high
//  start        in   1          begin build; accepted only in IDLE
//  sort_done    in   1          sorter round-complete pulse
//  ranks_unique in   1          sorter flag, sampled only with sort_done
//  emit_ready   in   1          downstream ready for emit_idx
//  busy         out  1          high in every state except IDLE
//  done         out  1          1-cycle pulse on successful completion
//  error        out  1          sticky timeout flag; cleared on accepted start
//  load_ranks   out  1          1-cycle pulse: sorter loads ranks from characters
//  sort_start   out  1          1-cycle pulse: sorter begins a round
//  rank_update  out  1          1-cycle pulse: sorter recomputes ranks after a round
//  offset       out  clog2(N)+1 current doubling offset (1<<h)
//  round_cnt    out  W          completed sort rounds in this build
//  emit_valid   out  1          emit_idx is valid
//  emit_idx     out  clog2(N)   SA position being emitted
//  emit_last    out  1          high with emit_valid when emit_idx==N-1
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0. offset=1. error=0.
//  States: IDLE, INIT, SORT_REQ, SORT_WAIT, RANK, EMIT, DONE.
//  IDLE: start=1 -> INIT, clear error/round_cnt, offset=1. start ignored elsewhere.
//  INIT (1 cyc): load_ranks=1 -> SORT_REQ.
//  SORT_REQ (1 cyc): sort_start=1 -> SORT_WAIT. Watchdog counter cleared.
//  SORT_WAIT: wait for sort_done. On sort_done: round_cnt+=1, latch ranks_unique -> RANK.
//    Watchdog reaches TIMEOUT-1 with no sort_done: error=1 -> IDLE. No done pulse.
//  RANK (1 cyc): rank_update=1. Terminate if latched unique==1 or offset==N -> EMIT.
//    Otherwise offset<<=1 -> SORT_REQ.
//  Max rounds = clog2(N)+1 (offsets 1..N). offset never exceeds N.
//  EMIT: emit_valid=1. emit_idx starts at 0. Advance only when emit_valid&emit_ready.
//    emit_idx/emit_last held stable while ready=0. Transfer at idx N-1 -> DONE.
//  DONE (1 cyc): done=1 -> IDLE. offset/round_cnt hold until next accepted start.
//  Latency: start at edge t -> load_ranks in t+1 -> sort_start in t+2.
//    sort_done at edge s -> rank_update in s+1 -> next sort_start in s+2.
//  sort_done outside SORT_WAIT: ignored, no state change.
//  sort_done in the same cycle as watchdog expiry: sort_done wins.
//  Async rst mid-operation: immediate return to IDLE, all outputs to reset values.
//  Status of pulse outputs: each asserted exactly one cycle per entry of its state.
// TESTING
//  1 Reset: assert rst mid-SORT_WAIT -> busy=0, offset=1, round_cnt=0 at once, no done.
//  2 N=8 "mississ$": ranks_unique=1 on 2nd sort_done -> sort_start x2, offsets 1,2.
//    round_cnt=2. Then emit_idx 0..7, emit_last on 7, then done pulse.
//  3 ranks_unique never set -> 4 rounds, offsets 1,2,4,8, round_cnt=4, then EMIT.
//  4 Backpressure: emit_ready low 3 cycles at idx 3 -> idx 3 held, no skip or duplicate.
//  5 Timeout: TIMEOUT=16, no sort_done -> error=1 after 16 cycles in SORT_WAIT, IDLE.
//    Next start clears error.
//  6 Spurious: start while busy and sort_done in EMIT -> no effect on sequence or counts.

Source files
------------

// File: rtl/mm_round_ctrl.sv
// Round sequencer for the prefix-doubling suffix-array sorter: initial rank load,
// one sort round per doubling offset, then streaming of SA positions to the BWT stage.
`timescale 1ns/1ps
module mm_round_ctrl #(
    parameter int N       = 8,
    parameter int W       = 4,
    parameter int TIMEOUT = 1024,
    localparam int OW     = $clog2(N) + 1,
    localparam int IW     = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          sort_done,
    input  logic          ranks_unique,
    input  logic          emit_ready,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic          load_ranks,
    output logic          sort_start,
    output logic          rank_update,
    output logic [OW-1:0] offset,
    output logic [W-1:0]  round_cnt,
    output logic          emit_valid,
    output logic [IW-1:0] emit_idx,
    output logic          emit_last
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, INIT, SORT_REQ, SORT_WAIT, RANK, EMIT, DONE
    } state_t;

    state_t         state;
    logic [WDW-1:0] wd;
    logic           uniq;

    assign busy       = (state != IDLE);
    assign emit_valid = (state == EMIT);
    assign emit_last  = emit_valid && (emit_idx == IW'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            done        <= 1'b0;
            error       <= 1'b0;
            load_ranks  <= 1'b0;
            sort_start  <= 1'b0;
            rank_update <= 1'b0;
            offset      <= OW'(1);
            round_cnt   <= '0;
            emit_idx    <= '0;
            wd          <= '0;
            uniq        <= 1'b0;
        end else begin
            load_ranks  <= 1'b0;
            sort_start  <= 1'b0;
            rank_update <= 1'b0;
            done        <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    error      <= 1'b0;
                    round_cnt  <= '0;
                    offset     <= OW'(1);
                    emit_idx   <= '0;
                    load_ranks <= 1'b1;
                    state      <= INIT;
                end
                INIT: begin
                    sort_start <= 1'b1;
                    state      <= SORT_REQ;
                end
                SORT_REQ: begin
                    wd    <= '0;
                    state <= SORT_WAIT;
                end
                // sort_done is checked first so it beats a same-cycle watchdog expiry
                SORT_WAIT: begin
                    if (sort_done) begin
                        round_cnt   <= round_cnt + W'(1);
                        uniq        <= ranks_unique;
                        rank_update <= 1'b1;
                        state       <= RANK;
                    end else if (wd == WDW'(TIMEOUT - 1)) begin
                        error <= 1'b1;
                        state <= IDLE;
                    end else begin
                        wd <= wd + WDW'(1);
                    end
                end
                RANK: begin
                    if (uniq || offset == OW'(N)) begin
                        state <= EMIT;
                    end else begin
                        offset     <= offset << 1;
                        sort_start <= 1'b1;
                        state      <= SORT_REQ;
                    end
                end
                EMIT: if (emit_ready) begin
                    emit_idx <= emit_idx + IW'(1);
                    if (emit_idx == IW'(N - 1)) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mm_round_ctrl.sv
// Scoreboard bench for mm_round_ctrl: expected offsets / emit indices are queued as
// stimulus is planned and popped by a negedge monitor as the DUT produces them.
`timescale 1ns/1ps
module tb_mm_round_ctrl;

    localparam int N  = 8;
    localparam int W  = 4;
    localparam int TO = 16;
    localparam int OW = $clog2(N) + 1;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0, sort_done = 1'b0, ranks_unique = 1'b0, emit_ready = 1'b1;
    logic          busy, done, error, load_ranks, sort_start, rank_update;
    logic [OW-1:0] offset;
    logic [W-1:0]  round_cnt;
    logic          emit_valid, emit_last;
    logic [IW-1:0] emit_idx;

    int vec = 0, err = 0;
    int n_ss = 0, n_ru = 0, n_done = 0;
    int exp_off[$];
    int exp_idx[$];

    mm_round_ctrl #(.N(N), .W(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .sort_done(sort_done),
        .ranks_unique(ranks_unique), .emit_ready(emit_ready), .busy(busy),
        .done(done), .error(error), .load_ranks(load_ranks), .sort_start(sort_start),
        .rank_update(rank_update), .offset(offset), .round_cnt(round_cnt),
        .emit_valid(emit_valid), .emit_idx(emit_idx), .emit_last(emit_last)
    );

    always #5 clk = ~clk;

    // Monitor: pops the scoreboard on every sort_start and every emit transfer
    always @(negedge clk) begin
        if (!rst) begin
            if (sort_start) begin
                n_ss++;
                vec++;
                if (exp_off.size() == 0) begin
                    err++; $display("FAIL sb_offset: unexpected sort_start offset=%0d", offset);
                end else begin
                    int e;
                    e = exp_off.pop_front();
                    if (offset !== OW'(e)) begin
                        err++; $display("FAIL sb_offset: got %0d want %0d", offset, e);
                    end
                end
            end
            if (emit_valid && emit_ready) begin
                vec++;
                if (exp_idx.size() == 0) begin
                    err++; $display("FAIL sb_emit: unexpected transfer idx=%0d", emit_idx);
                end else begin
                    int e;
                    e = exp_idx.pop_front();
                    if (emit_idx !== IW'(e) || emit_last !== (e == N - 1)) begin
                        err++; $display("FAIL sb_emit: got idx=%0d last=%0b want idx=%0d last=%0b",
                                        emit_idx, emit_last, e, (e == N - 1));
                    end
                end
            end
            if (rank_update) n_ru++;
            if (done) n_done++;
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // One full build: sorter reports unique on round uniq_at (0 = never)
    task automatic do_build(input string nm, input int uniq_at, input int rounds,
                            input int stall_idx, input int stall_len, input bit spur);
        int k, left;
        n_ss = 0; n_ru = 0; n_done = 0;
        for (int r = 0; r < rounds; r++) exp_off.push_back(1 << r);
        for (int i = 0; i < N; i++) exp_idx.push_back(i);
        emit_ready = 1'b1;
        pulse_start();
        @(negedge clk);
        vec++;
        if (load_ranks !== 1'b1 || error !== 1'b0 || busy !== 1'b1) begin
            err++; $display("FAIL %s_init: load=%0b err=%0b busy=%0b want 1 0 1", nm, load_ranks, error, busy);
        end
        @(negedge clk);
        vec++;
        if (sort_start !== 1'b1) begin
            err++; $display("FAIL %s_ss0: got %0b want 1", nm, sort_start);
        end
        for (int r = 0; r < rounds; r++) begin
            @(posedge clk); #1 start = spur;
            @(posedge clk); #1 start = 1'b0;
            @(posedge clk); #1 sort_done = 1'b1; ranks_unique = (r + 1 == uniq_at);
            @(posedge clk); #1 sort_done = 1'b0; ranks_unique = 1'b0;
            @(negedge clk);
            vec++;
            if (rank_update !== 1'b1 || round_cnt !== W'(r + 1)) begin
                err++; $display("FAIL %s_rank%0d: ru=%0b cnt=%0d want 1 %0d", nm, r, rank_update, round_cnt, r + 1);
            end
            @(negedge clk);
            vec++;
            if (r < rounds - 1) begin
                if (sort_start !== 1'b1) begin
                    err++; $display("FAIL %s_ss%0d: got %0b want 1", nm, r + 1, sort_start);
                end
            end else if (emit_valid !== 1'b1 || emit_idx !== '0 || sort_start !== 1'b0) begin
                err++; $display("FAIL %s_emit0: v=%0b idx=%0d ss=%0b want 1 0 0", nm, emit_valid, emit_idx, sort_start);
            end
        end
        k = 0; left = stall_len;
        for (int c = 0; c < 100 && k < N; c++) begin
            @(posedge clk);
            if (emit_ready) k++;
            if (k < N) begin
                #1;
                emit_ready = !(k == stall_idx && left > 0);
                if (!emit_ready) left--;
                sort_done = spur; ranks_unique = spur; start = spur;
                @(negedge clk);
                if (!emit_ready) begin
                    vec++;
                    if (emit_idx !== IW'(k) || emit_valid !== 1'b1) begin
                        err++; $display("FAIL %s_hold: idx=%0d v=%0b want %0d 1", nm, emit_idx, emit_valid, k);
                    end
                end
            end
        end
        #1 sort_done = 1'b0; ranks_unique = 1'b0; start = 1'b0; emit_ready = 1'b1;
        @(negedge clk);
        vec++;
        if (done !== 1'b1 || emit_valid !== 1'b0) begin
            err++; $display("FAIL %s_done: done=%0b v=%0b want 1 0", nm, done, emit_valid);
        end
        @(negedge clk);
        vec++;
        if (done !== 1'b0 || busy !== 1'b0 || offset !== OW'(1 << (rounds - 1)) || round_cnt !== W'(rounds)) begin
            err++; $display("FAIL %s_end: done=%0b busy=%0b off=%0d cnt=%0d want 0 0 %0d %0d",
                            nm, done, busy, offset, round_cnt, 1 << (rounds - 1), rounds);
        end
        vec++;
        if (n_ss != rounds || n_ru != rounds || n_done != 1 || exp_off.size() != 0 || exp_idx.size() != 0) begin
            err++; $display("FAIL %s_counts: ss=%0d ru=%0d done=%0d qoff=%0d qidx=%0d want %0d %0d 1 0 0",
                            nm, n_ss, n_ru, n_done, exp_off.size(), exp_idx.size(), rounds, rounds);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        vec++;
        if (busy !== 0 || done !== 0 || error !== 0 || offset !== OW'(1) || round_cnt !== 0 ||
            emit_valid !== 0 || load_ranks !== 0 || sort_start !== 0 || rank_update !== 0) begin
            err++; $display("FAIL reset_state: busy=%0b done=%0b err=%0b off=%0d cnt=%0d v=%0b", busy, done, error, offset, round_cnt, emit_valid);
        end
        @(posedge clk); #1 rst = 1'b0;
        n_done = 0;
        exp_off.push_back(1); exp_off.push_back(2);
        pulse_start();
        repeat (2) @(negedge clk);
        repeat (3) @(posedge clk);
        #1 sort_done = 1'b1;
        @(posedge clk); #1 sort_done = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        vec++;
        if (busy !== 0 || offset !== OW'(1) || round_cnt !== 0 || done !== 0) begin
            err++; $display("FAIL reset_mid: busy=%0b off=%0d cnt=%0d done=%0b want 0 1 0 0", busy, offset, round_cnt, done);
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        vec++;
        if (n_done != 0 || busy !== 0 || exp_off.size() != 0) begin
            err++; $display("FAIL reset_after: done_cnt=%0d busy=%0b qoff=%0d want 0 0 0", n_done, busy, exp_off.size());
        end
    endtask

    task automatic test_timeout();
        n_done = 0;
        exp_off.push_back(1);
        pulse_start();
        repeat (2) @(negedge clk);
        repeat (TO) @(negedge clk);
        vec++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            err++; $display("FAIL timeout_early: err=%0b busy=%0b want 0 1", error, busy);
        end
        @(negedge clk);
        vec++;
        if (error !== 1'b1 || busy !== 1'b0 || n_done != 0) begin
            err++; $display("FAIL timeout_fire: err=%0b busy=%0b done_cnt=%0d want 1 0 0", error, busy, n_done);
        end
        repeat (2) @(negedge clk);
        vec++;
        if (error !== 1'b1) begin
            err++; $display("FAIL timeout_sticky: err=%0b want 1", error);
        end
        do_build("timeout_clear", 1, 1, 5, 1, 1'b0);
    endtask

    initial begin
        test_reset();
        do_build("mississ", 2, 2, 99, 0, 1'b0);
        do_build("nonunique", 0, 4, 99, 0, 1'b0);
        do_build("backpressure", 1, 1, 3, 3, 1'b0);
        test_timeout();
        do_build("spurious", 3, 3, 6, 2, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
